phase_seq_ctrl: RTL and testbench

PHASE_SEQ_CTRL -- requirements
Module: phase_seq_ctrl

---
 rtl/phase_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_phase_seq_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_seq_ctrl.sv
// Phase sequencer: steps through a programmable table of {phase, dwell} entries,
// advancing on dwell expiry (auto) or on step pulses (manual), then holds off.
module phase_seq_ctrl #(
   parameter int DEPTH   = 64,
   parameter int HOLDOFF = 50000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [5:0]  wr_addr,
   input  logic [4:0]  wr_phase,
   input  logic [15:0] wr_dwell,
   input  logic [5:0]  n_last,
   input  logic        arm,
   input  logic        trigger,
   input  logic        step,
   input  logic        auto_mode,
   input  logic        abort,
   output logic [4:0]  phase_out,
   output logic        active,
   output logic [5:0]  index,
   output logic [1:0]  state,
   output logic        done
);

   localparam int HC_W = $clog2(HOLDOFF + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b10,
      S_HOLD = 2'b11
   } state_e;

   state_e            state_q;
   logic [5:0]        index_q;
   logic [5:0]        last_q;
   logic [4:0]        phase_q;
   logic [15:0]       dwell_cnt_q;
   logic [HC_W-1:0]   hold_cnt_q;
   logic              active_q;
   logic              done_q;

   logic [20:0]       table_q [DEPTH];

   logic [5:0]        index_d;
   logic [20:0]       firstEntry;
   logic [20:0]       nextEntry;
   logic              advance;

   assign index_d    = index_q + 6'd1;
   assign firstEntry = table_q[0];
   assign nextEntry  = table_q[index_d];
   assign advance    = auto_mode ? (dwell_cnt_q == 16'd0) : step;

   // Table is deliberately excluded from reset so a rerun after rst reuses the loaded sequence.
   always_ff @(posedge clk) begin
      if (!rst && wr_en && (state_q != S_RUN) && (int'(wr_addr) < DEPTH)) begin
         table_q[wr_addr] <= {wr_phase, wr_dwell};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         index_q     <= 6'd0;
         last_q      <= 6'd0;
         phase_q     <= 5'd0;
         dwell_cnt_q <= 16'd0;
         hold_cnt_q  <= '0;
         active_q    <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (trigger && arm) begin
                  state_q     <= S_RUN;
                  index_q     <= 6'd0;
                  last_q      <= n_last;
                  phase_q     <= firstEntry[20:16];
                  dwell_cnt_q <= firstEntry[15:0];
                  active_q    <= 1'b1;
               end
            end
            S_RUN: begin
               // Early exit wins over any advance in the same cycle and never signals done.
               if (abort || !arm) begin
                  state_q    <= S_HOLD;
                  index_q    <= 6'd0;
                  phase_q    <= 5'd0;
                  active_q   <= 1'b0;
                  hold_cnt_q <= '0;
               end else if (advance && (index_q == last_q)) begin
                  state_q    <= S_HOLD;
                  index_q    <= 6'd0;
                  phase_q    <= 5'd0;
                  active_q   <= 1'b0;
                  hold_cnt_q <= '0;
                  done_q     <= 1'b1;
               end else if (advance) begin
                  index_q     <= index_d;
                  phase_q     <= nextEntry[20:16];
                  dwell_cnt_q <= nextEntry[15:0];
               end else if (auto_mode) begin
                  dwell_cnt_q <= dwell_cnt_q - 16'd1;
               end
            end
            S_HOLD: begin
               if (hold_cnt_q == HC_W'(HOLDOFF - 1)) begin
                  state_q    <= S_IDLE;
                  hold_cnt_q <= '0;
               end else begin
                  hold_cnt_q <= hold_cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign phase_out = phase_q;
   assign active    = active_q;
   assign index     = index_q;
   assign state     = state_q;
   assign done      = done_q;

endmodule

// File: tb/tb_phase_seq_ctrl.sv
// Directed bench for phase_seq_ctrl with HOLDOFF=4; inputs change and outputs are
// sampled on the falling edge. Snapshot layout: {state, active, done, index, phase_out}.
module tb_phase_seq_ctrl;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [5:0]  wr_addr;
   logic [4:0]  wr_phase;
   logic [15:0] wr_dwell;
   logic [5:0]  n_last;
   logic        arm;
   logic        trigger;
   logic        step;
   logic        auto_mode;
   logic        abort;
   logic [4:0]  phase_out;
   logic        active;
   logic [5:0]  index;
   logic [1:0]  state;
   logic        done;

   int total = 0;
   int bad   = 0;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b10;
   localparam logic [1:0] ST_HOLD = 2'b11;

   phase_seq_ctrl #(.DEPTH(64), .HOLDOFF(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_phase  (wr_phase),
      .wr_dwell  (wr_dwell),
      .n_last    (n_last),
      .arm       (arm),
      .trigger   (trigger),
      .step      (step),
      .auto_mode (auto_mode),
      .abort     (abort),
      .phase_out (phase_out),
      .active    (active),
      .index     (index),
      .state     (state),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [14:0] snap();
      return {state, active, done, index, phase_out};
   endfunction

   function automatic logic [14:0] mk(input logic [1:0] s, input logic a, input logic d,
                                      input logic [5:0] i, input logic [4:0] p);
      return {s, a, d, i, p};
   endfunction

   task automatic cycle();
      @(negedge clk);
   endtask

   task automatic writeEntry(input logic [5:0] a, input logic [4:0] p, input logic [15:0] d);
      wr_en = 1'b1; wr_addr = a; wr_phase = p; wr_dwell = d;
      cycle();
      wr_en = 1'b0;
   endtask

   task automatic startRun();
      trigger = 1'b1;
      cycle();
      trigger = 1'b0;
   endtask

   task automatic stepOnce();
      step = 1'b1;
      cycle();
      step = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_phase = '0; wr_dwell = '0;
      n_last = '0; arm = 1'b0; trigger = 1'b0; step = 1'b0; auto_mode = 1'b1; abort = 1'b0;
      cycle(); cycle();
      if (snap() !== 15'd0) begin bad++; $display("[TB] FAIL reset_state: got %h want %h", snap(), 15'd0); end
      total++;
      rst = 1'b0;
      cycle();
      if (snap() !== 15'd0) begin bad++; $display("[TB] FAIL reset_idle: got %h want %h", snap(), 15'd0); end
      total++;
   endtask

   task automatic test_auto();
      logic [4:0] expPh  [6] = '{5'd3, 5'd3, 5'd3, 5'd7, 5'd12, 5'd12};
      logic [5:0] expIdx [6] = '{6'd0, 6'd0, 6'd0, 6'd1, 6'd2, 6'd2};
      writeEntry(6'd0, 5'd3, 16'd2);
      writeEntry(6'd1, 5'd7, 16'd0);
      writeEntry(6'd2, 5'd12, 16'd1);
      n_last = 6'd2; arm = 1'b1; auto_mode = 1'b1;
      startRun();
      for (int i = 0; i < 6; i++) begin
         if (snap() !== mk(ST_RUN, 1'b1, 1'b0, expIdx[i], expPh[i])) begin
            bad++; $display("[TB] FAIL auto_seq[%0d]: got %h want %h", i, snap(), mk(ST_RUN, 1'b1, 1'b0, expIdx[i], expPh[i]));
         end
         total++;
         cycle();
      end
      if (snap() !== mk(ST_HOLD, 1'b0, 1'b1, 6'd0, 5'd0)) begin
         bad++; $display("[TB] FAIL auto_done: got %h want %h", snap(), mk(ST_HOLD, 1'b0, 1'b1, 6'd0, 5'd0));
      end
      total++;
      for (int j = 0; j < 3; j++) begin
         cycle();
         if (snap() !== mk(ST_HOLD, 1'b0, 1'b0, 6'd0, 5'd0)) begin
            bad++; $display("[TB] FAIL auto_holdoff[%0d]: got %h want %h", j, snap(), mk(ST_HOLD, 1'b0, 1'b0, 6'd0, 5'd0));
         end
         total++;
      end
      cycle();
      if (snap() !== mk(ST_IDLE, 1'b0, 1'b0, 6'd0, 5'd0)) begin
         bad++; $display("[TB] FAIL auto_idle: got %h want %h", snap(), mk(ST_IDLE, 1'b0, 1'b0, 6'd0, 5'd0));
      end
      total++;
   endtask

   task automatic test_manual();
      auto_mode = 1'b0;
      startRun();
      for (int i = 0; i < 4; i++) begin
         if (snap() !== mk(ST_RUN, 1'b1, 1'b0, 6'd0, 5'd3)) begin
            bad++; $display("[TB] FAIL manual_wait[%0d]: got %h want %h", i, snap(), mk(ST_RUN, 1'b1, 1'b0, 6'd0, 5'd3));
         end
         total++;
         cycle();
      end
      stepOnce();
      if (snap() !== mk(ST_RUN, 1'b1, 1'b0, 6'd1, 5'd7)) begin
         bad++; $display("[TB] FAIL manual_step1: got %h want %h", snap(), mk(ST_RUN, 1'b1, 1'b0, 6'd1, 5'd7));
      end
      total++;
      cycle(); cycle();
      if (snap() !== mk(ST_RUN, 1'b1, 1'b0, 6'd1, 5'd7)) begin
         bad++; $display("[TB] FAIL manual_hold7: got %h want %h", snap(), mk(ST_RUN, 1'b1, 1'b0, 6'd1, 5'd7));
      end
      total++;
      stepOnce();
      if (snap() !== mk(ST_RUN, 1'b1, 1'b0, 6'd2, 5'd12)) begin
         bad++; $display("[TB] FAIL manual_step2: got %h want %h", snap(), mk(ST_RUN, 1'b1, 1'b0, 6'd2, 5'd12));
      end
      total++;
      stepOnce();
      if (snap() !== mk(ST_HOLD, 1'b0, 1'b1, 6'd0, 5'd0)) begin
         bad++; $display("[TB] FAIL manual_done: got %h want %h", snap(), mk(ST_HOLD, 1'b0, 1'b1, 6'd0, 5'd0));
      end
      total++;
      repeat (4) cycle();
      if (state !== ST_IDLE) begin bad++; $display("[TB] FAIL manual_idle: got %b want %b", state, ST_IDLE); end
      total++;
   endtask

   task automatic test_abort();
      auto_mode = 1'b0;
      startRun();
      stepOnce();
      step = 1'b1; abort = 1'b1;
      cycle();
      step = 1'b0; abort = 1'b0;
      if (snap() !== mk(ST_HOLD, 1'b0, 1'b0, 6'd0, 5'd0)) begin
         bad++; $display("[TB] FAIL abort_exit: got %h want %h", snap(), mk(ST_HOLD, 1'b0, 1'b0, 6'd0, 5'd0));
      end
      total++;
      repeat (4) cycle();
      if (state !== ST_IDLE) begin bad++; $display("[TB] FAIL abort_idle: got %b want %b", state, ST_IDLE); end
      total++;
   endtask

   task automatic test_disarm();
      auto_mode = 1'b0;
      startRun();
      stepOnce();
      arm = 1'b0;
      cycle();
      if (snap() !== mk(ST_HOLD, 1'b0, 1'b0, 6'd0, 5'd0)) begin
         bad++; $display("[TB] FAIL disarm_exit: got %h want %h", snap(), mk(ST_HOLD, 1'b0, 1'b0, 6'd0, 5'd0));
      end
      total++;
      arm = 1'b1; trigger = 1'b1;
      repeat (3) cycle();
      if (state !== ST_HOLD) begin bad++; $display("[TB] FAIL disarm_trig_ignored: got %b want %b", state, ST_HOLD); end
      total++;
      cycle();
      if (snap() !== mk(ST_IDLE, 1'b0, 1'b0, 6'd0, 5'd0)) begin
         bad++; $display("[TB] FAIL disarm_idle: got %h want %h", snap(), mk(ST_IDLE, 1'b0, 1'b0, 6'd0, 5'd0));
      end
      total++;
      cycle();
      trigger = 1'b0;
      if (snap() !== mk(ST_RUN, 1'b1, 1'b0, 6'd0, 5'd3)) begin
         bad++; $display("[TB] FAIL disarm_rerun: got %h want %h", snap(), mk(ST_RUN, 1'b1, 1'b0, 6'd0, 5'd3));
      end
      total++;
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      repeat (4) cycle();
   endtask

   task automatic test_write_during_run();
      auto_mode = 1'b1;
      startRun();
      wr_en = 1'b1; wr_addr = 6'd2; wr_phase = 5'd31; wr_dwell = 16'd1;
      cycle();
      wr_en = 1'b0;
      repeat (3) cycle();
      if (snap() !== mk(ST_RUN, 1'b1, 1'b0, 6'd2, 5'd12)) begin
         bad++; $display("[TB] FAIL run_write_ignored: got %h want %h", snap(), mk(ST_RUN, 1'b1, 1'b0, 6'd2, 5'd12));
      end
      total++;
      repeat (6) cycle();
      if (state !== ST_IDLE) begin bad++; $display("[TB] FAIL run_write_idle: got %b want %b", state, ST_IDLE); end
      total++;
      writeEntry(6'd2, 5'd31, 16'd1);
      startRun();
      repeat (4) cycle();
      if (snap() !== mk(ST_RUN, 1'b1, 1'b0, 6'd2, 5'd31)) begin
         bad++; $display("[TB] FAIL idle_write_used: got %h want %h", snap(), mk(ST_RUN, 1'b1, 1'b0, 6'd2, 5'd31));
      end
      total++;
      repeat (6) cycle();
      writeEntry(6'd2, 5'd12, 16'd1);
   endtask

   task automatic test_reset_mid_run();
      auto_mode = 1'b0;
      startRun();
      stepOnce();
      rst = 1'b1; wr_en = 1'b1; wr_addr = 6'd0; wr_phase = 5'd9; wr_dwell = 16'd5;
      cycle();
      rst = 1'b0; wr_en = 1'b0;
      if (snap() !== 15'd0) begin bad++; $display("[TB] FAIL reset_mid_run: got %h want %h", snap(), 15'd0); end
      total++;
      startRun();
      if (snap() !== mk(ST_RUN, 1'b1, 1'b0, 6'd0, 5'd3)) begin
         bad++; $display("[TB] FAIL reset_rerun0: got %h want %h", snap(), mk(ST_RUN, 1'b1, 1'b0, 6'd0, 5'd3));
      end
      total++;
      stepOnce();
      stepOnce();
      if (snap() !== mk(ST_RUN, 1'b1, 1'b0, 6'd2, 5'd12)) begin
         bad++; $display("[TB] FAIL reset_rerun2: got %h want %h", snap(), mk(ST_RUN, 1'b1, 1'b0, 6'd2, 5'd12));
      end
      total++;
      stepOnce();
      if (done !== 1'b1) begin bad++; $display("[TB] FAIL reset_rerun_done: got %b want %b", done, 1'b1); end
      total++;
      repeat (4) cycle();
   endtask

   initial begin
      test_reset();
      test_auto();
      test_manual();
      test_abort();
      test_disarm();
      test_write_during_run();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
